// File: rtl/instr_loader_encoder_pkg.sv
// rtl/instr_loader_encoder_pkg.sv - opcodes, field positions and format classification for the instruction loader
package instr_loader_encoder_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam int OP_LSB    = 27;
  localparam int RD_LSB    = 22;
  localparam int RS_LSB    = 17;
  localparam int RT_LSB    = 12;
  localparam int SHAMT_LSB = 7;
  localparam int ALUOP_LSB = 2;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_JI,
    FMT_JII,
    FMT_BAD
  } fmt_e;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [4:0]  aluop;
    logic [16:0] imm;
    logic [26:0] target;
  } instr_fields_t;

  function automatic fmt_e classify(input logic [4:0] op);
    case (op)
      OP_RTYPE:                                  return FMT_R;
      OP_BNE, OP_ADDI, OP_BLT, OP_SW, OP_LW:     return FMT_I;
      OP_J, OP_JAL, OP_SETX, OP_BEX:             return FMT_JI;
      OP_JR:                                     return FMT_JII;
      default:                                   return FMT_BAD;
    endcase
  endfunction

endpackage

// File: rtl/instr_loader_encoder_if.sv
// rtl/instr_loader_encoder_if.sv - field-bundle handshake and imem write port of the instruction loader
interface instr_loader_encoder_if #(
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_shamt;
  logic [4:0]        in_aluop;
  logic [16:0]       in_imm;
  logic [26:0]       in_target;
  logic              in_last;
  logic              imem_wren;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;

  // master: bundle source that also observes the imem write port
  modport master (
    output in_valid, in_op, in_rd, in_rs, in_rt, in_shamt, in_aluop, in_imm, in_target, in_last,
    input  in_ready, imem_wren, imem_addr, imem_data
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs, in_rt, in_shamt, in_aluop, in_imm, in_target, in_last,
    output in_ready, imem_wren, imem_addr, imem_data
  );
endinterface

// File: rtl/instr_loader_encoder_pack.sv
// rtl/instr_loader_encoder_pack.sv - combinational opcode classify and field packing into a 32-bit word
module instr_pack
  import instr_loader_encoder_pkg::*;
(
  input  instr_fields_t fields,
  output logic [31:0]   word,
  output logic          illegal
);

  fmt_e fmt;

  // Only the fields of the selected format are placed; everything else stays zero.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    fmt     = classify(fields.op);
    case (fmt)
      FMT_R:   word = {fields.op, fields.rd, fields.rs, fields.rt, fields.shamt, fields.aluop, 2'b00};
      FMT_I:   word = {fields.op, fields.rd, fields.rs, fields.imm};
      FMT_JI:  word = {fields.op, fields.target};
      FMT_JII: word = {fields.op, fields.rd, 22'd0};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_loader_encoder.sv
// rtl/instr_loader_encoder.sv - accepts field bundles, encodes them and writes imem sequentially from BASE_ADDR
module instr_loader_encoder
  import instr_loader_encoder_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  restart,
  instr_loader_encoder_if.slave bus,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  done,
  output logic                  err_op
);

  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE = 1;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

  instr_fields_t     fields;
  logic [31:0]       word;
  logic              illegal;
  logic              accept;
  logic              wren_q;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   count_next;

  assign fields = '{
    op:     bus.in_op,
    rd:     bus.in_rd,
    rs:     bus.in_rs,
    rt:     bus.in_rt,
    shamt:  bus.in_shamt,
    aluop:  bus.in_aluop,
    imm:    bus.in_imm,
    target: bus.in_target
  };

  instr_pack u_pack (
    .fields  (fields),
    .word    (word),
    .illegal (illegal)
  );

  assign bus.in_ready = ~full & ~done & ~restart & ~reset;
  assign accept       = bus.in_valid & bus.in_ready;
  assign count_next   = count + CNT_ONE;

  // Reset discards a write registered on the previous edge; restart lets it through.
  assign bus.imem_wren = wren_q & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr           <= BASE_C;
      count         <= '0;
      full          <= 1'b0;
      done          <= 1'b0;
      err_op        <= 1'b0;
      wren_q        <= 1'b0;
      bus.imem_addr <= '0;
      bus.imem_data <= '0;
    end else begin
      wren_q <= 1'b0;
      if (restart) begin
        ptr    <= BASE_C;
        count  <= '0;
        full   <= 1'b0;
        done   <= 1'b0;
        err_op <= 1'b0;
      end else if (accept) begin
        if (illegal) begin
          err_op <= 1'b1;
        end else begin
          wren_q        <= 1'b1;
          bus.imem_addr <= ptr;
          bus.imem_data <= word;
          ptr           <= ptr + PTR_ONE;
          count         <= count_next;
          full          <= (count_next == DEPTH_C);
          if (bus.in_last) begin
            done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_loader_encoder.sv
// tb/tb_instr_loader_encoder.sv - directed self-checking bench for instr_loader_encoder
module tb_instr_loader_encoder;

  logic        clock = 1'b0;
  logic        reset;
  logic        restart;
  logic [12:0] count;
  logic        full;
  logic        done;
  logic        err_op;
  int          tests = 0;
  int          fails = 0;

  instr_loader_encoder_if #(.ADDR_W(12)) bus ();

  instr_loader_encoder #(
    .ADDR_W    (12),
    .BASE_ADDR (0),
    .DEPTH     (4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .restart (restart),
    .bus     (bus.slave),
    .count   (count),
    .full    (full),
    .done    (done),
    .err_op  (err_op)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic bundle(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] shamt, input logic [4:0] aluop,
                        input logic [16:0] imm, input logic [26:0] target, input logic last);
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_rd     = rd;
    bus.in_rs     = rs;
    bus.in_rt     = rt;
    bus.in_shamt  = shamt;
    bus.in_aluop  = aluop;
    bus.in_imm    = imm;
    bus.in_target = target;
    bus.in_last   = last;
  endtask

  task automatic do_restart();
    bus.in_valid = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  logic [31:0] lw_words [4] = '{32'h4000_0000, 32'h4040_0001, 32'h4080_0002, 32'h40C0_0003};

  initial begin
    reset   = 1'b1;
    restart = 1'b0;
    bundle(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0, 1'b0);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_wren", bus.imem_wren, 0);
    check("rst_addr", bus.imem_addr, 0);
    check("rst_data", bus.imem_data, 0);
    check("rst_count", count, 0);
    check("rst_flags", {full, done, err_op}, 0);
    check("rst_ready", bus.in_ready, 0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", bus.in_ready, 1);

    // R add with junk in imm/target that must be masked
    @(negedge clock);
    bundle(5'b00000, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 17'h1ABCD, 27'h555_5555, 1'b0);
    tick();
    check("r_wren", bus.imem_wren, 1);
    check("r_addr", bus.imem_addr, 0);
    check("r_data", bus.imem_data, 32'h00C2_2000);
    check("r_count", count, 1);
    bus.in_valid = 1'b0;
    tick();
    check("r_wren_one_cycle", bus.imem_wren, 0);

    // addi then j back-to-back from a fresh pointer
    do_restart();
    check("restart_count", count, 0);
    bundle(5'b00101, 5'd5, 5'd0, 5'd31, 5'd31, 5'd31, 17'h1FFFF, 27'h7FF_FFFF, 1'b0);
    tick();
    check("addi_wren", bus.imem_wren, 1);
    check("addi_addr", bus.imem_addr, 0);
    check("addi_data", bus.imem_data, 32'h2941_FFFF);
    bundle(5'b00001, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 17'h1FFFF, 27'h000_0010, 1'b0);
    tick();
    check("j_wren", bus.imem_wren, 1);
    check("j_addr", bus.imem_addr, 1);
    check("j_data", bus.imem_data, 32'h0800_0010);
    check("j_count", count, 2);
    bus.in_valid = 1'b0;
    tick();
    check("j_wren_end", bus.imem_wren, 0);

    // illegal opcode flagged as last: consumed, no write, no done
    do_restart();
    bundle(5'b11111, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 17'd1, 27'd1, 1'b1);
    tick();
    check("bad_wren", bus.imem_wren, 0);
    check("bad_err", err_op, 1);
    check("bad_count", count, 0);
    check("bad_done", done, 0);
    check("bad_ready", bus.in_ready, 1);
    do_restart();
    check("restart_clears_err", err_op, 0);

    // six lw bundles into a depth-4 memory
    for (int k = 0; k < 6; k++) begin
      bundle(5'b01000, 5'(k), 5'd0, 5'd0, 5'd0, 5'd0, 17'(k), 27'd0, 1'b0);
      tick();
      if (k < 4) begin
        check("fill_wren", bus.imem_wren, 1);
        check("fill_addr", bus.imem_addr, 12'(k));
        check("fill_data", bus.imem_data, lw_words[k]);
      end else begin
        check("stall_wren", bus.imem_wren, 0);
      end
    end
    check("full_flag", full, 1);
    check("full_ready", bus.in_ready, 0);
    check("full_count", count, 4);
    check("full_last_addr", bus.imem_addr, 3);

    // restart in the cycle after an accept
    do_restart();
    check("restart_clears_full", full, 0);
    bundle(5'b00101, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 17'd3, 27'd0, 1'b0);
    tick();
    restart = 1'b1;
    bundle(5'b00111, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 17'd7, 27'd0, 1'b0);
    #1;
    check("rs_ready_low", bus.in_ready, 0);
    check("rs_prior_wren", bus.imem_wren, 1);
    check("rs_prior_data", bus.imem_data, 32'h2844_0003);
    tick();
    restart = 1'b0;
    check("rs_no_accept", bus.imem_wren, 0);
    check("rs_count0", count, 0);
    tick();
    check("rs_next_wren", bus.imem_wren, 1);
    check("rs_next_addr", bus.imem_addr, 0);
    check("rs_next_data", bus.imem_data, 32'h39C0_0007);
    check("rs_next_count", count, 1);

    // legal in_last: done with its write, then stall
    bundle(5'b00100, 5'd9, 5'd31, 5'd31, 5'd31, 5'd31, 17'h1FFFF, 27'h7FF_FFFF, 1'b1);
    tick();
    check("jr_wren", bus.imem_wren, 1);
    check("jr_addr", bus.imem_addr, 1);
    check("jr_data", bus.imem_data, 32'h2240_0000);
    check("jr_done", done, 1);
    check("jr_ready", bus.in_ready, 0);
    tick();
    check("done_stall_wren", bus.imem_wren, 0);
    check("done_stall_count", count, 2);

    // reset the cycle after an accept
    do_restart();
    bundle(5'b10110, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h123_4567, 1'b0);
    tick();
    check("bex_data", bus.imem_data, 32'hB123_4567);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("rst_kills_wren", bus.imem_wren, 0);
    tick();
    check("rst2_wren", bus.imem_wren, 0);
    check("rst2_data", bus.imem_data, 0);
    check("rst2_count", count, 0);
    reset = 1'b0;
    tick();
    check("rst2_flags", {full, done, err_op}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
